// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: an edge-triggered byte transmitter and a mid-bit
// sampling byte receiver sharing one clock and asynchronous reset.
module uart_transceiver #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_en,
  input  logic [7:0] uart_din,
  output logic       uart_tx_busy,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       uart_done,
  output logic [7:0] uart_data
);

  localparam int BPS_CNT = CLK_FREQ / BAUD_RATE;
  localparam int CW      = $clog2(BPS_CNT + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] BPS_LAST = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] BPS_MID  = CW'(BPS_CNT / 2);

  typedef enum logic [0:0] {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_t;
  typedef enum logic [0:0] {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_t;

  // ---------------- transmitter ----------------
  logic          en_d0_r, en_d1_r;
  logic          tx_start_s;
  tx_state_t     tx_state_r, tx_state_n;
  logic [CW-1:0] tx_clk_r, tx_clk_n;
  logic [3:0]    tx_bit_r, tx_bit_n;
  logic [7:0]    tx_shift_r, tx_shift_n;
  logic          txd_r, txd_n;
  logic          busy_r, busy_n;

  assign tx_start_s = en_d0_r & ~en_d1_r;

  // Request edge detector for uart_en
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_d0_r <= 1'b0;
      en_d1_r <= 1'b0;
    end else begin
      en_d0_r <= uart_en;
      en_d1_r <= en_d0_r;
    end
  end

  // Transmit state and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state_r <= TX_IDLE;
      tx_clk_r   <= CNT_ZERO;
      tx_bit_r   <= 4'd0;
      tx_shift_r <= 8'h00;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      tx_state_r <= tx_state_n;
      tx_clk_r   <= tx_clk_n;
      tx_bit_r   <= tx_bit_n;
      tx_shift_r <= tx_shift_n;
      txd_r      <= txd_n;
      busy_r     <= busy_n;
    end
  end

  // Transmit next-state: txd_n is the level of the bit that starts next cycle
  always_comb begin
    tx_state_n = tx_state_r;
    tx_clk_n   = tx_clk_r;
    tx_bit_n   = tx_bit_r;
    tx_shift_n = tx_shift_r;
    txd_n      = txd_r;
    busy_n     = busy_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (tx_start_s) begin
          tx_state_n = TX_SEND;
          tx_clk_n   = CNT_ZERO;
          tx_bit_n   = 4'd0;
          tx_shift_n = uart_din;
          txd_n      = 1'b0;
          busy_n     = 1'b1;
        end else begin
          txd_n  = 1'b1;
          busy_n = 1'b0;
        end
      end
      TX_SEND: begin
        if (tx_clk_r == BPS_LAST) begin
          tx_clk_n = CNT_ZERO;
          if (tx_bit_r == 4'd9) begin
            tx_state_n = TX_IDLE;
            txd_n      = 1'b1;
            busy_n     = 1'b0;
          end else begin
            tx_bit_n = tx_bit_r + 4'd1;
            if (tx_bit_r == 4'd8) begin
              txd_n = 1'b1;
            end else begin
              txd_n      = tx_shift_r[0];
              tx_shift_n = {1'b0, tx_shift_r[7:1]};
            end
          end
        end else begin
          tx_clk_n = tx_clk_r + CNT_ONE;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        txd_n      = 1'b1;
        busy_n     = 1'b0;
      end
    endcase
  end

  assign uart_txd     = txd_r;
  assign uart_tx_busy = busy_r;

  // ---------------- receiver ----------------
  logic          rx_s0_r, rx_s1_r, rx_d_r;
  logic          rx_fall_s;
  rx_state_t     rx_state_r, rx_state_n;
  logic [CW-1:0] rx_clk_r, rx_clk_n;
  logic [3:0]    rx_bit_r, rx_bit_n;
  logic [7:0]    rx_shift_r, rx_shift_n;
  logic [7:0]    rx_data_r, rx_data_n;
  logic          done_r, done_n;

  assign rx_fall_s = rx_d_r & ~rx_s1_r;

  // Synchronizer for the asynchronous rx pin plus one delay stage
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s0_r <= 1'b0;
      rx_s1_r <= 1'b0;
      rx_d_r  <= 1'b0;
    end else begin
      rx_s0_r <= uart_rxd;
      rx_s1_r <= rx_s0_r;
      rx_d_r  <= rx_s1_r;
    end
  end

  // Receive state and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state_r <= RX_IDLE;
      rx_clk_r   <= CNT_ZERO;
      rx_bit_r   <= 4'd0;
      rx_shift_r <= 8'h00;
      rx_data_r  <= 8'h00;
      done_r     <= 1'b0;
    end else begin
      rx_state_r <= rx_state_n;
      rx_clk_r   <= rx_clk_n;
      rx_bit_r   <= rx_bit_n;
      rx_shift_r <= rx_shift_n;
      rx_data_r  <= rx_data_n;
      done_r     <= done_n;
    end
  end

  // Receive next-state: all decisions are taken at the bit midpoint
  always_comb begin
    rx_state_n = rx_state_r;
    rx_clk_n   = rx_clk_r;
    rx_bit_n   = rx_bit_r;
    rx_shift_n = rx_shift_r;
    rx_data_n  = rx_data_r;
    done_n     = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_fall_s) begin
          rx_state_n = RX_RECV;
          rx_clk_n   = CNT_ZERO;
          rx_bit_n   = 4'd0;
        end else begin
          rx_state_n = RX_IDLE;
        end
      end
      RX_RECV: begin
        if (rx_clk_r == BPS_LAST) begin
          rx_clk_n = CNT_ZERO;
          rx_bit_n = rx_bit_r + 4'd1;
        end else begin
          rx_clk_n = rx_clk_r + CNT_ONE;
        end
        if (rx_clk_r == BPS_MID) begin
          if (rx_bit_r == 4'd0) begin
            // A start bit that has gone high again by mid-bit is a glitch
            if (rx_s1_r) begin
              rx_state_n = RX_IDLE;
            end else begin
              rx_state_n = RX_RECV;
            end
          end else if (rx_bit_r == 4'd9) begin
            rx_state_n = RX_IDLE;
            if (rx_s1_r) begin
              rx_data_n = rx_shift_r;
              done_n    = 1'b1;
            end else begin
              rx_data_n = rx_data_r;
            end
          end else begin
            rx_shift_n = {rx_s1_r, rx_shift_r[7:1]};
          end
        end else begin
          rx_shift_n = rx_shift_r;
        end
      end
      default: begin
        rx_state_n = RX_IDLE;
      end
    endcase
  end

  assign uart_done = done_r;
  assign uart_data = rx_data_r;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed/randomized bench for uart_transceiver: frame-level line model for
// the transmitter and an expected-byte queue for the receiver.
`timescale 1ns/1ps
module tb_uart_transceiver;

  localparam int BPS = 50_000_000 / 115200;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       uart_en;
  logic [7:0] uart_din;
  logic       uart_tx_busy;
  logic       uart_txd;
  logic       uart_rxd;
  logic       uart_done;
  logic [7:0] uart_data;

  logic       loop_en;
  logic       rx_drv;
  logic       prev_done;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  assign uart_rxd = loop_en ? uart_txd : rx_drv;

  uart_transceiver #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .uart_tx_busy (uart_tx_busy),
    .uart_txd     (uart_txd),
    .uart_rxd     (uart_rxd),
    .uart_done    (uart_done),
    .uart_data    (uart_data)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receive monitor: collects every valid byte and checks pulse width
  always @(negedge sys_clk) begin
    if (sys_rst_n === 1'b1) begin
      if (uart_done === 1'b1) begin
        chk("done_width", {31'd0, prev_done}, 32'd0);
        got_q.push_back(uart_data);
      end
      prev_done <= uart_done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic send_byte(input logic [7:0] b, input int len);
    uart_din = b;
    uart_en  = 1'b1;
    repeat (len) @(negedge sys_clk);
    uart_en  = 1'b0;
  endtask

  // Checks one whole transmitted frame against the 8N1 line model
  task automatic tx_frame(input logic [7:0] b, input string tag, input int inject_at, input logic [7:0] other);
    int   waited;
    int   k;
    logic dropped;
    waited  = 0;
    dropped = 1'b0;
    while (uart_tx_busy !== 1'b1 && waited < 20) begin
      @(negedge sys_clk);
      waited++;
    end
    chk({tag, "_busy_rise"}, {31'd0, uart_tx_busy}, 32'd1);
    for (int c = 0; c < 10 * BPS; c++) begin
      if (c == inject_at) begin
        uart_din = other;
        uart_en  = 1'b1;
      end
      if (c == inject_at + 3) uart_en = 1'b0;
      if (uart_tx_busy !== 1'b1) dropped = 1'b1;
      if ((c % BPS) == 0 || (c % BPS) == BPS - 1) begin
        k = c / BPS;
        chk($sformatf("%s_bit%0d_%0d", tag, k, c % BPS), {31'd0, uart_txd}, {31'd0, frame_bit(b, k)});
      end
      @(negedge sys_clk);
    end
    chk({tag, "_busy_held"}, {31'd0, dropped}, 32'd0);
    chk({tag, "_busy_fall"}, {31'd0, uart_tx_busy}, 32'd0);
    chk({tag, "_txd_idle"}, {31'd0, uart_txd}, 32'd1);
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = bits[k];
      repeat (BPS) @(negedge sys_clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic check_rx_queue(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    #1_900_000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       bad;
    sys_rst_n = 1'b0;
    uart_en   = 1'b0;
    uart_din  = 8'h00;
    loop_en   = 1'b0;
    rx_drv    = 1'b1;
    #11;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("rst_txd",  {31'd0, uart_txd},     32'd1);
    chk("rst_busy", {31'd0, uart_tx_busy}, 32'd0);
    chk("rst_done", {31'd0, uart_done},    32'd0);
    chk("rst_data", {24'd0, uart_data},    32'd0);
    repeat (50) @(negedge sys_clk);
    chk("idle_busy", {31'd0, uart_tx_busy}, 32'd0);
    chk("idle_rx",   got_q.size(), 32'd0);

    // Directed 0xA5 frame with a two-cycle request pulse
    send_byte(8'hA5, 2);
    tx_frame(8'hA5, "a5", -100, 8'h00);
    bad = 1'b0;
    repeat (1000) begin
      @(negedge sys_clk);
      if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) bad = 1'b1;
    end
    chk("a5_single_frame", {31'd0, bad}, 32'd0);
    chk("a5_no_rx", got_q.size(), 32'd0);

    // Loopback: directed zeros/twos then random bytes
    loop_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b = (i < 4) ? 8'h00 : (i < 7) ? 8'h02 : 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, 1);
      tx_frame(b, $sformatf("lb%0d", i), -100, 8'h00);
    end
    repeat (3) @(negedge sys_clk);
    check_rx_queue("loop");

    // Request and data change mid-frame must be ignored
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    send_byte(b, 1);
    tx_frame(b, "mid", 2000, ~b);
    bad = 1'b0;
    repeat (4500) begin
      @(negedge sys_clk);
      if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) bad = 1'b1;
    end
    chk("mid_no_second_frame", {31'd0, bad}, 32'd0);
    check_rx_queue("mid");

    // Short low glitch on rx, then a real frame to show the receiver is idle
    loop_en = 1'b0;
    rx_drv  = 1'b0;
    repeat (100) @(negedge sys_clk);
    rx_drv  = 1'b1;
    repeat (1000) @(negedge sys_clk);
    chk("glitch_count", got_q.size(), exp_q.size());
    chk("glitch_data", {24'd0, uart_data}, {24'd0, exp_q[exp_q.size()-1]});
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    drive_rx(b, 1'b1);
    repeat (20) @(negedge sys_clk);
    check_rx_queue("post_glitch");

    // Framing error: stop bit held low
    drive_rx(~b, 1'b0);
    repeat (500) @(negedge sys_clk);
    chk("ferr_count", got_q.size(), exp_q.size());
    chk("ferr_data", {24'd0, uart_data}, {24'd0, exp_q[exp_q.size()-1]});

    // Reset in the middle of a transmit frame
    send_byte(8'($urandom_range(0, 255)), 1);
    repeat (200) @(negedge sys_clk);
    chk("pre_rst_busy", {31'd0, uart_tx_busy}, 32'd1);
    chk("pre_rst_txd",  {31'd0, uart_txd},     32'd0);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_txd",  {31'd0, uart_txd},     32'd1);
    chk("mid_rst_busy", {31'd0, uart_tx_busy}, 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("mid_rst_data", {24'd0, uart_data}, 32'd0);
    loop_en = 1'b1;
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    send_byte(b, 1);
    tx_frame(b, "post_rst", -100, 8'h00);
    repeat (3) @(negedge sys_clk);
    check_rx_queue("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
